// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the fetch/mem-stage cache port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int BE_W       = DATA_W_DEF / 8;
  localparam int STARVE_SAT = 15;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundles the fetch, mem-stage and cache-side signals of the arbiter.
// Latency: n/a (wiring only).
// Backpressure: pulse request / pulse ack; requesters hold off until their ack.
interface mem_arbiter_if import mem_arb_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  localparam int BW = DATA_W / 8;

  // fetch side
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;
  // mem-stage side
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [BW-1:0]     d_be;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  // cache side
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BW-1:0]     mem_be;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  // status
  logic              proto_err;

  // arbiter view
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ack, mem_rdata,
    output i_ack, i_rdata, d_ack, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be, proto_err
  );

  // requester + cache view
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ack, mem_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be, proto_err
  );

endinterface

// File: rtl/mem_arbiter_req_slot.sv
// One pending-request register: captures a request pulse, holds it until cleared.
// Latency: contents and full flag visible the cycle after the load pulse.
// Backpressure: none; a load into a full slot is dropped and flags a sticky error.
module req_slot import mem_arb_pkg::*; #(
  parameter int AW = ADDR_W_DEF,
  parameter int DW = DATA_W_DEF,
  parameter int BW = BE_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          clear,
  input  logic          in_we,
  input  logic [AW-1:0] in_addr,
  input  logic [DW-1:0] in_wdata,
  input  logic [BW-1:0] in_be,
  output logic          full,
  output logic          q_we,
  output logic [AW-1:0] q_addr,
  output logic [DW-1:0] q_wdata,
  output logic [BW-1:0] q_be,
  output logic          err
);

  // A slot being retired this cycle can take the owner's next request at once.
  logic accept;
  assign accept = load & (~full | clear);

  // Full flag: refill wins over clear so back-to-back requests never lose a cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         full <= 1'b0;
    else if (accept) full <= 1'b1;
    else if (clear)  full <= 1'b0;
  end

  // Fields only change on an accepted load, so a dropped request cannot disturb the one in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_we    <= 1'b0;
      q_addr  <= '0;
      q_wdata <= '0;
      q_be    <= '0;
    end else if (accept) begin
      q_we    <= in_we;
      q_addr  <= in_addr;
      q_wdata <= in_wdata;
      q_be    <= in_be;
    end
  end

  // Sticky protocol error: requester pulsed again before its previous request completed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          err <= 1'b0;
    else if (load && full && !clear)  err <= 1'b1;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one cache port between fetch (I) and mem stage (D); D has priority, fetch is anti-starved.
// Latency: request cycle 0 -> mem_req cycle 1; requester ack in the same cycle as mem_ack.
// Backpressure: one transaction outstanding; requests are held in per-side slots until served.
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int STARVE_MAX = 4,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);
  localparam int BW = DATA_W / 8;

  state_t            state, state_n;
  owner_t            owner, owner_n, pick;
  logic [3:0]        starve_cnt;
  logic              grant_i, grant_d;

  logic              i_full, i_clr, i_err, i_we_q;
  logic [ADDR_W-1:0] i_addr_q;
  logic [DATA_W-1:0] i_wdata_q;
  logic [BW-1:0]     i_be_q;
  logic              d_full, d_clr, d_err, d_we_q;
  logic [ADDR_W-1:0] d_addr_q;
  logic [DATA_W-1:0] d_wdata_q;
  logic [BW-1:0]     d_be_q;

  // fetch only carries an address; the write-side fields are tied off
  req_slot #(.AW(ADDR_W), .DW(DATA_W), .BW(BW)) u_i_slot (
    .clk      (clk),
    .rst      (rst),
    .load     (bus.i_req),
    .clear    (i_clr),
    .in_we    (1'b0),
    .in_addr  (bus.i_addr),
    .in_wdata ({DATA_W{1'b0}}),
    .in_be    ({BW{1'b0}}),
    .full     (i_full),
    .q_we     (i_we_q),
    .q_addr   (i_addr_q),
    .q_wdata  (i_wdata_q),
    .q_be     (i_be_q),
    .err      (i_err)
  );

  req_slot #(.AW(ADDR_W), .DW(DATA_W), .BW(BW)) u_d_slot (
    .clk      (clk),
    .rst      (rst),
    .load     (bus.d_req),
    .clear    (d_clr),
    .in_we    (bus.d_we),
    .in_addr  (bus.d_addr),
    .in_wdata (bus.d_wdata),
    .in_be    (bus.d_be),
    .full     (d_full),
    .q_we     (d_we_q),
    .q_addr   (d_addr_q),
    .q_wdata  (d_wdata_q),
    .q_be     (d_be_q),
    .err      (d_err)
  );

  assign bus.proto_err = i_err | d_err;

  // D wins unless fetch has already waited through STARVE_MAX consecutive D grants
  assign pick = (d_full && (!i_full || int'(starve_cnt) < STARVE_MAX)) ? OWN_D : OWN_I;

  // State and owner registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      owner <= OWN_I;
    end else begin
      state <= state_n;
      owner <= owner_n;
    end
  end

  // Consecutive D grants seen by a waiting fetch; any I grant or empty I slot restarts the count
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   starve_cnt <= 4'd0;
    else if (!i_full || grant_i)               starve_cnt <= 4'd0;
    else if (grant_d && int'(starve_cnt) != STARVE_SAT) starve_cnt <= starve_cnt + 4'd1;
  end

  // Next state, one-cycle cache request with the owner's fields, ack/data routing back to the owner
  always_comb begin
    state_n       = state;
    owner_n       = owner;
    grant_i       = 1'b0;
    grant_d       = 1'b0;
    i_clr         = 1'b0;
    d_clr         = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_be    = '0;
    bus.i_ack     = 1'b0;
    bus.i_rdata   = '0;
    bus.d_ack     = 1'b0;
    bus.d_rdata   = '0;
    case (state)
      IDLE: begin
        if (i_full || d_full) begin
          bus.mem_req = 1'b1;
          owner_n     = pick;
          state_n     = BUSY;
          if (pick == OWN_D) begin
            grant_d       = 1'b1;
            bus.mem_we    = d_we_q;
            bus.mem_addr  = d_addr_q;
            bus.mem_wdata = d_wdata_q;
            bus.mem_be    = d_be_q;
          end else begin
            grant_i       = 1'b1;
            bus.mem_we    = i_we_q;
            bus.mem_addr  = i_addr_q;
            bus.mem_wdata = i_wdata_q;
            bus.mem_be    = i_be_q;
          end
        end
      end
      BUSY: begin
        if (bus.mem_ack) begin
          state_n = IDLE;
          if (owner == OWN_D) begin
            bus.d_ack   = 1'b1;
            bus.d_rdata = d_we_q ? '0 : bus.mem_rdata;
            d_clr       = 1'b1;
          end else begin
            bus.i_ack   = 1'b1;
            bus.i_rdata = bus.mem_rdata;
            i_clr       = 1'b1;
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios plus randomized traffic.
// Latency: expectations carry the exact cycle each cache request / ack must appear.
// Backpressure: bench plays both requesters and the cache, with variable cache delay.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   ack_mode = 0;  // 0 random delay, 1 zero-wait, 2 manual

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  mem_arbiter #(.STARVE_MAX(SMAX), .ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct { int cyc; logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; logic [BW-1:0] be; } mem_exp_t;
  typedef struct { int cyc; bit side_d; logic [DW-1:0] data; } ack_exp_t;
  typedef struct { int cyc; bit is_ack; bit d; logic [63:0] val; } obs_t;

  mem_exp_t mem_q[$];
  ack_exp_t ack_q[$];
  obs_t     obs[$];

  // reference model: pending requests per side, who owns the port, fetch wait count
  bit m_busy, m_own_d, m_err, exp_err;
  bit ip_v, dp_v, dp_we;
  logic [AW-1:0] ip_addr, dp_addr;
  logic [DW-1:0] dp_wdata;
  logic [BW-1:0] dp_be;
  int m_wait;  // D grants issued since the current fetch request became visible

  function automatic void model_reset();
    m_busy = 0; m_own_d = 0; m_err = 0; exp_err = 0;
    ip_v = 0; dp_v = 0; m_wait = 0;
    mem_q.delete(); ack_q.delete();
  endfunction

  function automatic void model_step();
    mem_exp_t e;
    ack_exp_t a;
    exp_err = m_err;
    if (!m_busy && (ip_v || dp_v)) begin
      m_own_d = dp_v && (!ip_v || m_wait < SMAX);
      e.cyc = cyc;
      if (m_own_d) begin
        e.we = dp_we; e.addr = dp_addr; e.wdata = dp_wdata; e.be = dp_be;
        if (ip_v && m_wait < 15) m_wait++;
      end else begin
        e.we = 1'b0; e.addr = ip_addr; e.wdata = '0; e.be = '0;
        m_wait = 0;
      end
      mem_q.push_back(e);
      m_busy = 1;
    end else if (m_busy && bus.mem_ack) begin
      a.cyc = cyc; a.side_d = m_own_d;
      a.data = (m_own_d && dp_we) ? '0 : bus.mem_rdata;
      ack_q.push_back(a);
      if (m_own_d) dp_v = 0; else ip_v = 0;
      m_busy = 0;
    end
    if (bus.i_req) begin
      if (ip_v) m_err = 1;
      else begin ip_v = 1; ip_addr = bus.i_addr; m_wait = 0; end
    end
    if (bus.d_req) begin
      if (dp_v) m_err = 1;
      else begin dp_v = 1; dp_we = bus.d_we; dp_addr = bus.d_addr; dp_wdata = bus.d_wdata; dp_be = bus.d_be; end
    end
  endfunction

  task automatic chk(input string nm, input longint got, input longint expv);
    n_vec++;
    if (got != expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, expv);
    end
  endtask

  function automatic obs_t ev(int i);
    obs_t o;
    o.cyc = -1; o.is_ack = 0; o.d = 0; o.val = '1;
    if (i < obs.size()) o = obs[i];
    return o;
  endfunction

  task automatic chk_ev(input string nm, input int i, input int c, input bit is_ack, input bit d, input longint v);
    obs_t o;
    o = ev(i);
    chk($sformatf("%s_ev%0d_cycle", nm, i), o.cyc, c);
    chk($sformatf("%s_ev%0d_kind", nm, i), {o.is_ack, o.d}, {is_ack, d});
    chk($sformatf("%s_ev%0d_value", nm, i), o.val, v);
  endtask

  task automatic cache_drive();
    case (ack_mode)
      0: begin
        if (m_busy) begin
          if ($urandom_range(0, 2) == 0) begin bus.mem_ack = 1; bus.mem_rdata = $urandom; end
        end else if ($urandom_range(0, 7) == 0) begin
          bus.mem_ack = 1; bus.mem_rdata = $urandom;  // stray ack while idle
        end
      end
      1: if (m_busy) begin bus.mem_ack = 1; bus.mem_rdata = 32'h1000_0000 + 32'(cyc); end
      default: ;
    endcase
  endtask

  // inputs for the current cycle are set by the caller; this scores them and advances one clock
  task automatic next();
    if (!rst) model_step();
    @(posedge clk); #1;
    bus.i_req = 0; bus.d_req = 0; bus.mem_ack = 0; bus.mem_rdata = '0;
    cache_drive();
  endtask

  task automatic do_reset();
    rst = 1; model_reset();
    bus.i_req = 0; bus.d_req = 0; bus.mem_ack = 0; bus.mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    obs.delete();
  endtask

  // monitor: pops the scoreboard whenever the DUT shows a request/ack or one is due
  always @(negedge clk) begin : monitor
    mem_exp_t me;
    ack_exp_t ae;
    obs_t o;
    bit due_m, due_a, x_ia, x_da;
    logic [DW-1:0] x_ir, x_dr;
    if (!rst) begin
      due_m = (mem_q.size() > 0) && (mem_q[0].cyc == cyc);
      due_a = (ack_q.size() > 0) && (ack_q[0].cyc == cyc);
      if (bus.mem_req) begin
        o.cyc = cyc; o.is_ack = 0; o.d = bus.mem_we; o.val = 64'(bus.mem_addr); obs.push_back(o);
      end
      if (bus.i_ack || bus.d_ack) begin
        o.cyc = cyc; o.is_ack = 1; o.d = bus.d_ack;
        o.val = 64'(bus.d_ack ? bus.d_rdata : bus.i_rdata); obs.push_back(o);
      end
      if (bus.mem_req || due_m) begin
        n_vec++;
        if (!due_m) begin
          n_bad++; $display("FAIL mem_req cyc %0d: got mem_req=1, expected no request", cyc);
        end else begin
          me = mem_q.pop_front();
          if (!bus.mem_req || bus.mem_we !== me.we || bus.mem_addr !== me.addr ||
              bus.mem_wdata !== me.wdata || bus.mem_be !== me.be) begin
            n_bad++;
            $display("FAIL mem_req cyc %0d: got req=%0b we=%0b addr=%h wdata=%h be=%h, expected req=1 we=%0b addr=%h wdata=%h be=%h",
                     cyc, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be, me.we, me.addr, me.wdata, me.be);
          end
        end
      end
      if (bus.i_ack || bus.d_ack || due_a) begin
        n_vec++;
        x_ia = 0; x_da = 0; x_ir = '0; x_dr = '0;
        if (due_a) begin
          ae = ack_q.pop_front();
          if (ae.side_d) begin x_da = 1; x_dr = ae.data; end
          else begin x_ia = 1; x_ir = ae.data; end
        end
        if (bus.i_ack !== x_ia || bus.d_ack !== x_da || bus.i_rdata !== x_ir || bus.d_rdata !== x_dr) begin
          n_bad++;
          $display("FAIL ack cyc %0d: got i_ack=%0b i_rdata=%h d_ack=%0b d_rdata=%h, expected i_ack=%0b i_rdata=%h d_ack=%0b d_rdata=%h",
                   cyc, bus.i_ack, bus.i_rdata, bus.d_ack, bus.d_rdata, x_ia, x_ir, x_da, x_dr);
        end
      end
      n_vec++;
      if (bus.proto_err !== exp_err ||
          (!bus.mem_req && ({bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be} != '0)) ||
          (!bus.i_ack && bus.i_rdata != '0) || (!bus.d_ack && bus.d_rdata != '0)) begin
        n_bad++;
        $display("FAIL quiet cyc %0d: got proto_err=%0b mem_req=%0b mem_addr=%h i_rdata=%h d_rdata=%h, expected proto_err=%0b and idle fields 0",
                 cyc, bus.proto_err, bus.mem_req, bus.mem_addr, bus.i_rdata, bus.d_rdata, exp_err);
      end
    end
  end

  initial begin : stim
    int c0, np;
    bit ack_i, ack_d, rude;
    rst = 1;
    bus.i_req = 0; bus.i_addr = '0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0;
    bus.d_wdata = '0; bus.d_be = '0; bus.mem_ack = 0; bus.mem_rdata = '0;
    model_reset();
    #1;
    do_reset();

    // reset state
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_acks", {bus.i_ack, bus.d_ack}, 0);
    chk("rst_proto_err", bus.proto_err, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_state", dut.state, IDLE);

    // single fetch, cache answers 4 cycles after the request
    ack_mode = 2; obs.delete(); c0 = cyc;
    bus.i_req = 1; bus.i_addr = 32'h100; next();
    next(); next(); next();
    bus.mem_ack = 1; bus.mem_rdata = 32'h0000_0013; next();
    repeat (3) next();
    chk("single_events", obs.size(), 2);
    chk_ev("single", 0, c0 + 1, 0, 0, 64'h100);
    chk_ev("single", 1, c0 + 4, 1, 0, 64'h13);

    // simultaneous I load + D store on a zero-wait cache: D first, I right behind
    ack_mode = 1; obs.delete(); c0 = cyc;
    bus.i_req = 1; bus.i_addr = 32'h200;
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h8000; bus.d_wdata = 32'hDEAD_BEEF; bus.d_be = 4'hF;
    next();
    repeat (6) next();
    chk("simul_events", obs.size(), 4);
    chk_ev("simul", 0, c0 + 1, 0, 1, 64'h8000);
    chk_ev("simul", 1, c0 + 2, 1, 1, 64'h0);
    chk_ev("simul", 2, c0 + 3, 0, 0, 64'h200);
    chk_ev("simul", 3, c0 + 4, 1, 0, 64'(32'h1000_0000 + 32'(c0 + 4)));

    // starvation: D re-pulsed at every d_ack while fetch waits
    obs.delete(); np = 0;
    bus.i_req = 1; bus.i_addr = 32'h400;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h9000;
    next();
    for (int k = 0; k < 20; k++) begin
      if (bus.mem_ack && m_busy && m_own_d && np < 5) begin
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h9000; np++;
      end
      next();
    end
    for (int k = 0; k < 4; k++) chk($sformatf("starve_d_grant%0d", k), ev(2 * k).val, 64'h9000);
    chk("starve_i_grant_addr", ev(8).val, 64'h400);
    chk("starve_i_ack", {ev(9).is_ack, ev(9).d}, 2'b10);
    chk("starve_cnt_cleared", dut.starve_cnt, 0);

    // protocol error: second fetch pulse while the first is still outstanding
    do_reset(); ack_mode = 2; c0 = cyc;
    bus.i_req = 1; bus.i_addr = 32'h300; next();
    next();
    bus.i_req = 1; bus.i_addr = 32'h304; next();
    next();
    bus.mem_ack = 1; bus.mem_rdata = 32'h55; next();
    repeat (4) next();
    chk("proto_err_sticky", bus.proto_err, 1);
    chk("proto_events", obs.size(), 2);
    chk_ev("proto", 0, c0 + 1, 0, 0, 64'h300);
    chk_ev("proto", 1, c0 + 4, 1, 0, 64'h55);

    // reset while BUSY, then a stale ack two cycles after release
    do_reset(); ack_mode = 2;
    bus.i_req = 1; bus.i_addr = 32'h500; next();
    next();
    rst = 1; model_reset(); next();
    rst = 0; obs.delete();
    next(); next();
    bus.mem_ack = 1; bus.mem_rdata = 32'hBAD; next();
    repeat (3) next();
    chk("rst_busy_events", obs.size(), 0);
    chk("rst_busy_state", dut.state, IDLE);

    // randomized traffic, mostly well-behaved requesters, occasional protocol violations
    do_reset(); ack_mode = 0;
    for (int k = 0; k < 1500; k++) begin
      ack_i = bus.mem_ack && m_busy && !m_own_d;
      ack_d = bus.mem_ack && m_busy && m_own_d;
      rude  = ($urandom_range(0, 63) == 0);
      bus.i_addr = $urandom; bus.d_addr = $urandom; bus.d_wdata = $urandom;
      bus.d_we = 1'($urandom); bus.d_be = 4'($urandom);
      if ((!ip_v || ack_i || rude) && $urandom_range(0, 3) == 0) bus.i_req = 1;
      if ((!dp_v || ack_d || rude) && $urandom_range(0, 1) == 0) bus.d_req = 1;
      next();
    end
    ack_mode = 1;
    repeat (20) next();
    chk("drain_mem_q", mem_q.size(), 0);
    chk("drain_ack_q", ack_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single cache/memory port between the fetch stage (instruction reads) and the memory stage (loads and stores).
- Each requester keeps the pulse-request / ack-response protocol that fetch already uses. The arbiter latches requests, grants one transaction at a time and routes the ack and read data back to the owner.
- Data side has fixed priority over instruction side. A starvation counter guarantees fetch progress.

Parameters:
- STARVE_MAX, 4: consecutive D grants allowed while an I request is pending; the next grant is then forced to I (range 1..15).
- ADDR_W, 32: address width.
- DATA_W, 32: data width (byte enables = DATA_W/8).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- i_req  in  1  fetch request pulse (fetch addr_ready)
- i_addr  in  ADDR_W  fetch address, valid with i_req
- i_ack  out  1  one-cycle pulse, instruction returned
- i_rdata  out  DATA_W  instruction, valid with i_ack, else 0
- d_req  in  1  mem-stage request pulse
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_be  in  DATA_W/8  store byte enables
- d_ack  out  1  one-cycle pulse, load data returned or store done
- d_rdata  out  DATA_W  load data with d_ack (0 for stores and when idle)
- mem_req  out  1  one-cycle pulse to cache
- mem_we, mem_addr, mem_wdata, mem_be  out  1/ADDR_W/DATA_W/DATA_W/8  transaction fields, valid with mem_req, else 0
- mem_ack  in  1  one-cycle pulse from cache
- mem_rdata  in  DATA_W  valid with mem_ack
- proto_err  out  1  sticky: request received while the same side already pending

Behaviour:
- Reset (async, rst high): state IDLE, both slots empty, starve_cnt 0, proto_err 0, all outputs 0.
- Slots:
  - On i_req, the I slot captures i_addr.
  - On d_req, the D slot captures d_we/d_addr/d_wdata/d_be.
  - Both may load in the same cycle.
  - A request to an already-full slot is dropped (original contents kept) and sets proto_err.
  - Slot contents become visible to the arbiter the cycle after the request.
- FSM IDLE:
  - If any slot is full, select an owner and assert mem_req with the owner's fields for exactly one cycle, record the owner, then go to BUSY.
  - If no slot is full, stay in IDLE.
  - mem_ack received in IDLE is ignored.
- Owner selection:
  - D slot full and (I slot empty or starve_cnt < STARVE_MAX) -> D.
  - Otherwise -> I.
- FSM BUSY:
  - mem_req low. Wait for mem_ack.
  - On mem_ack: pulse the owner's ack in the same cycle. Pass mem_rdata to i_rdata, or to d_rdata for a load (d_rdata = 0 for a store). Clear the owner's slot and return to IDLE.
  - A new request for the owner's side in the mem_ack cycle is accepted, not an error.
  - A new request from the other side while BUSY is latched normally.
- starve_cnt:
  - Increments (saturating at 15) on each D grant while the I slot is full.
  - Clears on an I grant, and in any cycle where the I slot is empty.
- Latency: request at cycle 0 -> mem_req at cycle 1 -> requester ack in the same cycle as mem_ack. Back-to-back: the next mem_req fires the cycle after mem_ack.
- Never more than one outstanding cache transaction. i_ack and d_ack are never high together.
- Reset mid-transaction: everything is cleared. A stale mem_ack arriving after reset hits IDLE and is ignored. Requesters are reset by the same rst.

Decomposition:
- Package mem_arb_pkg:
  - state_t {IDLE, BUSY}
  - owner_t {OWN_I, OWN_D}
  - localparam BE_W = DATA_W/8
- Sub-module req_slot: one pending-request register with load/clear/full/proto-error logic. Instantiated twice (I uses only the address field; the unused inputs are tied to 0).

Test Plan:
- Single fetch: i_req with i_addr=0x100 at cycle 0 -> mem_req=1, mem_addr=0x100, mem_we=0 at cycle 1. mem_ack with rdata=0x00000013 at cycle 4 -> i_ack=1, i_rdata=0x13 at cycle 4, d_ack stays 0.
- Simultaneous requests: i_req 0x200 and d_req (store 0x8000, wdata 0xDEADBEEF, be 0xF) in the same cycle -> D issued first, d_ack with d_rdata=0. I is issued the cycle after that mem_ack and returns via i_ack.
- Starvation with STARVE_MAX=4: I pending and d_req re-pulsed at each d_ack -> exactly 4 D grants, then an I grant, then starve_cnt=0.
- Protocol error: i_req twice (0x300, then 0x304) before i_ack -> proto_err=1 sticky, issued address is 0x300, only one i_ack.
- Reset mid-BUSY: rst after mem_req; mem_ack arrives 2 cycles after release -> no i_ack or d_ack, no mem_req, state IDLE.
- Zero-wait cache: mem_ack in the cycle after each mem_req, with I and D both pending -> mem_req at cycles 1 and 3, acks at cycles 2 and 4.
